video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 The module SHALL have parameter H_BITS, default 12, meaning the width of horizontal counters and config fields.
REQ-002 The module SHALL have parameter V_BITS, default 12, meaning the width of vertical counters and config fields.
REQ-003 The module SHALL have parameter FCNT_BITS, default 16, meaning the width of the frame counter.
REQ-004 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-005 Port rstb, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port i_en, input, 1 bit: run request; high starts or continues frame generation.
REQ-007 Port i_oneshot, input, 1 bit: sampled at frame start; 1 generates exactly one frame, then returns to IDLE.
REQ-008 Ports cfg_width (H_BITS), cfg_height (V_BITS), cfg_hblank (H_BITS) and cfg_vblank (V_BITS) are inputs giving active pixels/line, active lines, blank cycles/line and blank lines/frame.
REQ-009 Outputs hav and vav, 1 bit each: horizontal-active and vertical-active strobes.
REQ-010 Outputs o_x (H_BITS) and o_y (V_BITS): current pixel column/row; valid when hav&vav.
REQ-011 Outputs o_sof, o_eol and o_eof, 1 bit each: single-cycle pulses on the first pixel of a frame, the last pixel of each active line, and the last pixel of a frame.
REQ-012 Output o_busy, 1 bit: high while not IDLE.
REQ-013 Output o_cfg_err, 1 bit: start refused due to invalid config.
REQ-014 Output o_frame_cnt, FCNT_BITS: completed-frame count.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DRAIN; all outputs SHALL be registered.
REQ-016 Config SHALL be copied into shadow registers only on the IDLE-to-RUN transition and at each frame wrap; mid-frame cfg changes SHALL have no effect.
REQ-017 Each line SHALL be cfg_width+cfg_hblank cycles, with h_cnt running 0..W+HB-1.
REQ-018 Each frame SHALL be cfg_height+cfg_vblank lines, with v_cnt running 0..H+VB-1.
REQ-019 hav SHALL be 1 iff h_cnt<W and v_cnt<H; hav SHALL be 0 throughout vertical blank.
REQ-020 vav SHALL be 1 iff v_cnt<H, including during that line's horizontal blank.
REQ-021 o_x SHALL equal h_cnt and o_y SHALL equal v_cnt when hav&vav, and both SHALL be 0 otherwise.
REQ-022 On the edge sampling IDLE&i_en with valid config, the FSM SHALL enter RUN with h_cnt=v_cnt=0 and hav=vav=o_sof=1 (1-cycle latency from i_en).
REQ-023 Config SHALL be invalid if cfg_width==0 or cfg_height==0; IDLE&i_en with invalid config SHALL keep IDLE, hold hav=vav=0 and set o_cfg_err=1.
REQ-024 o_cfg_err SHALL stay 1 until the next valid start.
REQ-025 hblank=0 and/or vblank=0 SHALL be legal: hav stays high across consecutive active lines, and frames abut with no gap.
REQ-026 At frame end (h_cnt=W+HB-1, v_cnt=H+VB-1), o_frame_cnt SHALL increment, wrapping modulo 2^FCNT_BITS.
REQ-027 In RUN, if i_en=1 and latched oneshot=0 at frame end, a new frame SHALL start on the next cycle with no gap.
REQ-028 In RUN, if i_en=0 or latched oneshot=1 at frame end, the FSM SHALL enter IDLE.
REQ-029 i_en falling mid-frame in RUN SHALL move the FSM to DRAIN; DRAIN SHALL complete the frame unchanged, then enter IDLE.
REQ-030 i_en re-asserted during DRAIN SHALL return the FSM to RUN with no visible change.
REQ-031 o_eol SHALL assert when hav&vav and h_cnt==W-1; o_eof SHALL assert when hav&vav, h_cnt==W-1 and v_cnt==H-1.
REQ-032 When W=H=1, o_sof, o_eol and o_eof SHALL assert together on the single active pixel.
REQ-033 In IDLE, hav, vav, o_x, o_y and all pulses SHALL be 0.

Reset
REQ-034 While rstb=0: state=IDLE, all counters 0, hav=vav=o_sof=o_eol=o_eof=o_busy=o_cfg_err=0, o_x=o_y=0, o_frame_cnt=0.
REQ-035 Reset asserted mid-frame SHALL force reset values immediately (asynchronously), and the frame SHALL be discarded without incrementing o_frame_cnt.
REQ-036 After rstb rises, no frame SHALL start until i_en is sampled high.

Verification
REQ-037 W=4,H=2,HB=2,VB=1, i_en=1, oneshot=0 -> 18-cycle frame; per line hav=1111_00 on lines 0-1, 000000 on line 2; o_eol at x=3; o_eof at (3,1); o_frame_cnt 0->1 at cycle 18; next o_sof at cycle 19.
REQ-038 Same config, oneshot=1 -> exactly one frame, o_frame_cnt=1, o_busy falls the cycle after the last blank cycle.
REQ-039 Drop i_en at (x=2,y=0) -> DRAIN completes all 18 cycles, then IDLE; re-raising i_en in DRAIN -> continuous frames.
REQ-040 cfg_width=0, i_en=1 -> o_cfg_err=1, hav=vav=0, o_busy=0; then W=4 -> start next cycle and o_cfg_err=0.
REQ-041 Change cfg_width 4->6 mid-frame -> current frame keeps 4 pixels/line; next frame uses 6.
REQ-042 W=1,H=1,HB=0,VB=0 -> hav=vav=1 every cycle; o_sof=o_eol=o_eof=1 every cycle; o_frame_cnt increments every cycle and wraps at FCNT_BITS=4 after 16.

Source files
------------

// File: rtl/video_timing_gen.sv
// Video timing generator: raster counters, active strobes, frame pulses and a
// run/drain/idle controller. Config is shadowed at frame start so that
// mid-frame config writes only take effect from the next frame.
module video_timing_gen #(
   parameter int H_BITS    = 12,
   parameter int V_BITS    = 12,
   parameter int FCNT_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 i_en,
   input  logic                 i_oneshot,
   input  logic [H_BITS-1:0]    cfg_width,
   input  logic [V_BITS-1:0]    cfg_height,
   input  logic [H_BITS-1:0]    cfg_hblank,
   input  logic [V_BITS-1:0]    cfg_vblank,
   output logic                 hav,
   output logic                 vav,
   output logic [H_BITS-1:0]    o_x,
   output logic [V_BITS-1:0]    o_y,
   output logic                 o_sof,
   output logic                 o_eol,
   output logic                 o_eof,
   output logic                 o_busy,
   output logic                 o_cfg_err,
   output logic [FCNT_BITS-1:0] o_frame_cnt
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t              state, n_state;
   logic [H_BITS-1:0]   h_cnt, n_h, sh_w, n_sw, sh_hb, n_shb;
   logic [V_BITS-1:0]   v_cnt, n_v, sh_h, n_sh, sh_vb, n_svb;
   logic                os_lat, n_os, n_err, load, cfg_ok;
   logic [H_BITS:0]     h_inc, h_len, nh_inc, nh_len;
   logic [V_BITS:0]     v_inc, v_len, nv_inc, nv_len;
   logic                line_end, frame_end;
   logic                n_act, n_hav, n_vav, n_eol, n_fend;

   localparam logic [H_BITS:0]    H_ONE = {{H_BITS{1'b0}}, 1'b1};
   localparam logic [V_BITS:0]    V_ONE = {{V_BITS{1'b0}}, 1'b1};
   localparam logic [FCNT_BITS-1:0] F_ONE = {{(FCNT_BITS-1){1'b0}}, 1'b1};

   // Next-state decode: FSM transitions, counter advance and shadow reload
   always_comb begin
      n_state = state;
      n_h     = h_cnt;
      n_v     = v_cnt;
      n_sw    = sh_w;
      n_sh    = sh_h;
      n_shb   = sh_hb;
      n_svb   = sh_vb;
      n_os    = os_lat;
      n_err   = o_cfg_err;
      load    = 1'b0;
      cfg_ok  = (cfg_width != '0) && (cfg_height != '0);
      // Extra bit on the sums keeps W+HB and H+VB exact at full field width
      h_inc     = {1'b0, h_cnt} + H_ONE;
      h_len     = {1'b0, sh_w} + {1'b0, sh_hb};
      v_inc     = {1'b0, v_cnt} + V_ONE;
      v_len     = {1'b0, sh_h} + {1'b0, sh_vb};
      line_end  = (h_inc == h_len);
      frame_end = line_end && (v_inc == v_len);
      case (state)
         IDLE: begin
            if (i_en) begin
               if (cfg_ok) begin
                  n_state = RUN;
                  load    = 1'b1;
               end else begin
                  n_err = 1'b1;
               end
            end
         end
         default: begin
            if (frame_end) begin
               if (i_en && !os_lat && cfg_ok) begin
                  n_state = RUN;
                  load    = 1'b1;
               end else begin
                  n_state = IDLE;
                  n_h     = '0;
                  n_v     = '0;
                  if (i_en && !os_lat) n_err = 1'b1;
               end
            end else begin
               // DRAIN only differs from RUN in what happens at frame end
               n_state = i_en ? RUN : DRAIN;
               if (line_end) begin
                  n_h = '0;
                  n_v = v_inc[V_BITS-1:0];
               end else begin
                  n_h = h_inc[H_BITS-1:0];
               end
            end
         end
      endcase
      if (load) begin
         n_h   = '0;
         n_v   = '0;
         n_sw  = cfg_width;
         n_sh  = cfg_height;
         n_shb = cfg_hblank;
         n_svb = cfg_vblank;
         n_os  = i_oneshot;
         n_err = 1'b0;
      end
   end

   // Output decode from the next counter values so every output is registered
   always_comb begin
      n_act  = (n_state != IDLE);
      n_vav  = n_act && (n_v < n_sh);
      n_hav  = n_vav && (n_h < n_sw);
      nh_inc = {1'b0, n_h} + H_ONE;
      nh_len = {1'b0, n_sw} + {1'b0, n_shb};
      nv_inc = {1'b0, n_v} + V_ONE;
      nv_len = {1'b0, n_sh} + {1'b0, n_svb};
      n_eol  = n_hav && (nh_inc == {1'b0, n_sw});
      n_fend = n_act && (nh_inc == nh_len) && (nv_inc == nv_len);
   end

   // State, counters, shadow config and registered outputs
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state       <= IDLE;
         h_cnt       <= '0;
         v_cnt       <= '0;
         sh_w        <= '0;
         sh_h        <= '0;
         sh_hb       <= '0;
         sh_vb       <= '0;
         os_lat      <= 1'b0;
         hav         <= 1'b0;
         vav         <= 1'b0;
         o_x         <= '0;
         o_y         <= '0;
         o_sof       <= 1'b0;
         o_eol       <= 1'b0;
         o_eof       <= 1'b0;
         o_busy      <= 1'b0;
         o_cfg_err   <= 1'b0;
         o_frame_cnt <= '0;
      end else begin
         state     <= n_state;
         h_cnt     <= n_h;
         v_cnt     <= n_v;
         sh_w      <= n_sw;
         sh_h      <= n_sh;
         sh_hb     <= n_shb;
         sh_vb     <= n_svb;
         os_lat    <= n_os;
         hav       <= n_hav;
         vav       <= n_vav;
         o_x       <= n_hav ? n_h : '0;
         o_y       <= n_hav ? n_v : '0;
         o_sof     <= n_act && (n_h == '0) && (n_v == '0);
         o_eol     <= n_eol;
         o_eof     <= n_eol && (nv_inc == {1'b0, n_sh});
         o_busy    <= n_act;
         o_cfg_err <= n_err;
         if (n_fend) o_frame_cnt <= o_frame_cnt + F_ONE;
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen: 4x2 raster with HB=2, VB=1 as the
// reference frame, plus drain, oneshot, config error, shadowing, async reset
// and the degenerate 1x1 raster.
module tb_video_timing_gen;

   localparam int H_BITS    = 12;
   localparam int V_BITS    = 12;
   localparam int FCNT_BITS = 4;

   logic                 clk, rstb, i_en, i_oneshot;
   logic [H_BITS-1:0]    cfg_width, cfg_hblank;
   logic [V_BITS-1:0]    cfg_height, cfg_vblank;
   logic                 hav, vav, o_sof, o_eol, o_eof, o_busy, o_cfg_err;
   logic [H_BITS-1:0]    o_x;
   logic [V_BITS-1:0]    o_y;
   logic [FCNT_BITS-1:0] o_frame_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic hav, vav, sof, eol, eof;
      int   x, y;
   } vec_t;

   vec_t tbl[18];

   video_timing_gen #(.H_BITS(H_BITS), .V_BITS(V_BITS), .FCNT_BITS(FCNT_BITS)) dut (
      .clk(clk), .rstb(rstb), .i_en(i_en), .i_oneshot(i_oneshot),
      .cfg_width(cfg_width), .cfg_height(cfg_height),
      .cfg_hblank(cfg_hblank), .cfg_vblank(cfg_vblank),
      .hav(hav), .vav(vav), .o_x(o_x), .o_y(o_y),
      .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
      .o_busy(o_busy), .o_cfg_err(o_cfg_err), .o_frame_cnt(o_frame_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Compare outputs against reference-frame entry c
   task automatic chk_vec(input int c, input int fc);
      string t;
      t = $sformatf("c%0d", c);
      chk({t, "_hav"}, hav,   tbl[c].hav);
      chk({t, "_vav"}, vav,   tbl[c].vav);
      chk({t, "_x"},   o_x,   tbl[c].x);
      chk({t, "_y"},   o_y,   tbl[c].y);
      chk({t, "_sof"}, o_sof, tbl[c].sof);
      chk({t, "_eol"}, o_eol, tbl[c].eol);
      chk({t, "_eof"}, o_eof, tbl[c].eof);
      chk({t, "_busy"}, o_busy, 1);
      chk({t, "_fcnt"}, o_frame_cnt, fc);
   endtask

   task automatic chk_idle(input string name, input int fc);
      chk({name, "_busy"}, o_busy, 0);
      chk({name, "_hav"},  hav,    0);
      chk({name, "_vav"},  vav,    0);
      chk({name, "_sof"},  o_sof,  0);
      chk({name, "_fcnt"}, o_frame_cnt, fc);
   endtask

   initial begin
      // Reference frame W=4 H=2 HB=2 VB=1: lines of 6 cycles, 3 lines
      for (int c = 0; c < 18; c++) begin
         int px, ln;
         px = c % 6;
         ln = c / 6;
         tbl[c].vav = (ln < 2);
         tbl[c].hav = (ln < 2) && (px < 4);
         tbl[c].x   = tbl[c].hav ? px : 0;
         tbl[c].y   = tbl[c].hav ? ln : 0;
         tbl[c].sof = (c == 0);
         tbl[c].eol = tbl[c].hav && (px == 3);
         tbl[c].eof = tbl[c].hav && (px == 3) && (ln == 1);
      end

      rstb = 1'b0; i_en = 1'b0; i_oneshot = 1'b0;
      cfg_width = 4; cfg_height = 2; cfg_hblank = 2; cfg_vblank = 1;
      step(); step();
      chk_idle("rst", 0);
      chk("rst_x", o_x, 0);
      chk("rst_y", o_y, 0);
      chk("rst_eol", o_eol, 0);
      chk("rst_eof", o_eof, 0);
      chk("rst_err", o_cfg_err, 0);

      rstb = 1'b1;
      step();
      chk_idle("no_en", 0);

      // Frame A then B back to back; drop i_en at (2,0) of B
      i_en = 1'b1;
      for (int c = 0; c < 18; c++) begin
         step(); chk_vec(c, (c == 17) ? 1 : 0);
      end
      for (int c = 0; c < 18; c++) begin
         step(); chk_vec(c, (c == 17) ? 2 : 1);
         if (c == 2) i_en = 1'b0;
      end
      step();
      chk_idle("drain_end", 2);

      // Frame C: drop and re-raise inside DRAIN, then continuous frame D
      i_en = 1'b1;
      for (int c = 0; c < 18; c++) begin
         step(); chk_vec(c, (c == 17) ? 3 : 2);
         if (c == 2) i_en = 1'b0;
         if (c == 8) i_en = 1'b1;
      end
      step(); chk_vec(0, 3);
      i_en = 1'b0;
      for (int c = 1; c < 18; c++) begin
         step(); chk_vec(c, (c == 17) ? 4 : 3);
      end
      step();
      chk_idle("d_end", 4);

      // Oneshot latched at frame start; i_en held high through the end
      i_en = 1'b1; i_oneshot = 1'b1;
      step(); chk_vec(0, 4);
      i_oneshot = 1'b0;
      for (int c = 1; c < 18; c++) begin
         step(); chk_vec(c, (c == 17) ? 5 : 4);
      end
      step();
      chk_idle("oneshot_end", 5);
      i_en = 1'b0;
      step();
      chk_idle("oneshot_idle", 5);

      // Invalid config refused, then accepted once width is fixed
      cfg_width = 0; i_en = 1'b1;
      step();
      chk("err_set", o_cfg_err, 1);
      chk_idle("err1", 5);
      step();
      chk("err_hold", o_cfg_err, 1);
      chk_idle("err2", 5);
      cfg_width = 4;
      step(); chk_vec(0, 5);
      chk("err_clr", o_cfg_err, 0);

      // Mid-frame width change applies only to the next frame
      cfg_width = 6;
      for (int c = 1; c < 18; c++) begin
         step(); chk_vec(c, (c == 17) ? 6 : 5);
      end
      step();
      chk("w6_sof", o_sof, 1);
      chk("w6_hav0", hav, 1);
      for (int c = 1; c <= 6; c++) begin
         step();
         if (c == 5) begin
            chk("w6_x5", o_x, 5);
            chk("w6_hav5", hav, 1);
            chk("w6_eol5", o_eol, 1);
         end
         if (c == 6) begin
            chk("w6_hav6", hav, 0);
            chk("w6_vav6", vav, 1);
            chk("w6_eol6", o_eol, 0);
         end
      end
      i_en = 1'b0;
      begin
         int n;
         n = 0;
         while (o_busy && n < 40) begin
            step();
            n++;
         end
         chk("w6_drain_done", o_busy, 0);
         chk("w6_drain_cycles", n, 18);
      end
      chk("w6_fcnt", o_frame_cnt, 7);

      // Asynchronous reset mid-frame discards the frame
      cfg_width = 4; i_en = 1'b1;
      repeat (5) step();
      chk("pre_rst_busy", o_busy, 1);
      #2 rstb = 1'b0;
      #1;
      chk_idle("async_rst", 0);
      chk("async_rst_x", o_x, 0);
      i_en = 1'b0;
      step();
      #2 rstb = 1'b1;
      step();
      chk_idle("post_rst1", 0);
      step();
      chk_idle("post_rst2", 0);

      // 1x1 raster, no blanking: every cycle is a complete frame
      cfg_width = 1; cfg_height = 1; cfg_hblank = 0; cfg_vblank = 0;
      i_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         string t;
         t = $sformatf("k%0d", k);
         step();
         chk({t, "_hav"}, hav, 1);
         chk({t, "_vav"}, vav, 1);
         chk({t, "_sof"}, o_sof, 1);
         chk({t, "_eol"}, o_eol, 1);
         chk({t, "_eof"}, o_eof, 1);
         chk({t, "_fcnt"}, o_frame_cnt, (k + 1) % 16);
      end
      i_en = 1'b0;
      step(); step();
      chk("w1_idle", o_busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
